csr_file: RTL and testbench

//  Machine-mode CSR responder for the 3-stage RV32I pipeline. Consumes the execute-stage CSR request
//  (type_e2csr_data_s: data = forwarded rs1, addr = imm32) and returns the read value for writeback.

---
 rtl/csr_file_pkg.sv | 50 +++++
 rtl/csr_file_cycle_counter.sv | 37 +++
 rtl/csr_file.sv | 161 ++++++++++++++++
 tb/tb_csr_file.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Shared types and constants for the machine-mode CSR block: CSR numbers,
// op encoding, trap causes and the execute-to-CSR request payload.
package csr_file_pkg;

  localparam int unsigned CSR_AW     = 12;
  localparam int unsigned REQ_W      = 32;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH = 12'hB80;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIE_MTIE     = 7;

  localparam logic [REQ_W-1:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [REQ_W-1:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } type_csr_op_e;

  typedef struct packed {
    logic [REQ_W-1:0] data;
    logic [REQ_W-1:0] addr;
  } type_e2csr_data_s;

  // Read-modify-write result of a CSR instruction.
  function automatic logic [REQ_W-1:0] csr_apply(type_csr_op_e op, logic [REQ_W-1:0] old_v,
                                                 logic [REQ_W-1:0] wdata);
    logic [REQ_W-1:0] res;
    case (op)
      CSR_RW:  res = wdata;
      CSR_RS:  res = old_v | wdata;
      CSR_RC:  res = old_v & ~wdata;
      default: res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_cycle_counter.sv
// 64-bit free-running cycle counter; a write to either half replaces that
// half and holds the other, with no increment or carry in that cycle.
module csr_cycle_counter #(
  parameter int unsigned HALF_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_lo_i,
  input  logic                wr_hi_i,
  input  logic [HALF_W-1:0]   wdata_i,
  output logic [2*HALF_W-1:0] count_o
);

  localparam int unsigned CNT_W = 2 * HALF_W;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (wr_lo_i) begin
      count_d = {count_q[CNT_W-1:HALF_W], wdata_i};
    end else if (wr_hi_i) begin
      count_d = {wdata_i, count_q[HALF_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR responder: zero-latency CSR reads, M/W-stage writes,
// interrupt trap entry and mret return that redirect fetch.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_rd,
  input  logic                 csr_wr,
  input  type_csr_op_e         csr_op,
  input  type_e2csr_data_s     e2csr_data,
  input  logic [BUS_WIDTH-1:0] pc,
  input  logic                 is_mret,
  input  logic                 ext_intr,
  input  logic                 timer_intr,
  output logic [BUS_WIDTH-1:0] csr_rdata,
  output logic                 csr_illegal,
  output logic                 epc_taken,
  output logic [BUS_WIDTH-1:0] epc
);

  logic                 mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic                 meie_q, meie_d, mtie_q, mtie_d;
  logic [BUS_WIDTH-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [2*BUS_WIDTH-1:0] mcycle;
  logic [CSR_AW-1:0]    csr_addr;
  logic [BUS_WIDTH-1:0] mstatus_v, mie_v, mip_v, rdata_c, wdata_c;
  logic [BUS_WIDTH-1:0] trap_base, trap_cause, trap_vec;
  logic                 addr_ok, addr_wr, ext_take, irq, wr_en, wr_lo, wr_hi;
  logic                 unused_bits;

  assign csr_addr    = e2csr_data.addr[CSR_AW-1:0];
  assign unused_bits = ^{e2csr_data.addr[REQ_W-1:CSR_AW], pc[1:0]};

  // Architectural views of the sparse status/enable/pending registers.
  always_comb begin
    mstatus_v               = '0;
    mstatus_v[MSTATUS_MIE]  = mst_mie_q;
    mstatus_v[MSTATUS_MPIE] = mst_mpie_q;
    mie_v                   = '0;
    mie_v[MIE_MEIE]         = meie_q;
    mie_v[MIE_MTIE]         = mtie_q;
    mip_v                   = '0;
    mip_v[MIE_MEIE]         = ext_intr;
    mip_v[MIE_MTIE]         = timer_intr;
  end

  always_comb begin
    rdata_c = '0;
    addr_ok = 1'b1;
    addr_wr = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: rdata_c = mstatus_v;
      CSR_MIE:     rdata_c = mie_v;
      CSR_MTVEC:   rdata_c = mtvec_q;
      CSR_MEPC:    rdata_c = mepc_q;
      CSR_MCAUSE:  rdata_c = mcause_q;
      CSR_MIP: begin
        rdata_c = mip_v;
        addr_wr = 1'b0;
      end
      CSR_MCYCLE:  rdata_c = mcycle[BUS_WIDTH-1:0];
      CSR_MCYCLEH: rdata_c = mcycle[2*BUS_WIDTH-1:BUS_WIDTH];
      default: begin
        addr_ok = 1'b0;
        addr_wr = 1'b0;
      end
    endcase
  end

  assign wdata_c  = csr_apply(csr_op, rdata_c, e2csr_data.data);
  assign ext_take = ext_intr & meie_q;
  assign irq      = mst_mie_q & (ext_take | (timer_intr & mtie_q));
  assign wr_en    = csr_wr & (csr_op != CSR_NONE) & addr_wr & ~irq;
  assign wr_lo    = wr_en & (csr_addr == CSR_MCYCLE);
  assign wr_hi    = wr_en & (csr_addr == CSR_MCYCLEH);

  // Trap entry outranks mret, which outranks a plain CSR write to mstatus.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = wdata_c[MSTATUS_MIE];
          mst_mpie_d = wdata_c[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          meie_d = wdata_c[MIE_MEIE];
          mtie_d = wdata_c[MIE_MTIE];
        end
        CSR_MTVEC:  mtvec_d  = wdata_c;
        CSR_MEPC:   mepc_d   = {wdata_c[BUS_WIDTH-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = wdata_c;
        default: ;
      endcase
    end
    if (irq) begin
      mepc_d     = {pc[BUS_WIDTH-1:2], 2'b00};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mcause_d   = trap_cause;
    end else if (is_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_cycle_counter #(
    .HALF_W (BUS_WIDTH)
  ) u_cycle (
    .clk     (clk),
    .reset   (reset),
    .wr_lo_i (wr_lo),
    .wr_hi_i (wr_hi),
    .wdata_i (wdata_c),
    .count_o (mcycle)
  );

  // Vectored mode: cause code * 4 is the cause shifted left, interrupt bit dropping out.
  assign trap_cause = ext_take ? CAUSE_MEI : CAUSE_MTI;
  assign trap_base  = {mtvec_q[BUS_WIDTH-1:2], 2'b00};
  assign trap_vec   = (mtvec_q[1:0] == 2'b01) ? trap_base + {trap_cause[BUS_WIDTH-3:0], 2'b00}
                                              : trap_base;

  assign csr_rdata   = rdata_c;
  assign csr_illegal = ~reset & (csr_rd | csr_wr) & ~addr_ok;
  assign epc_taken   = ~reset & (irq | is_mret);
  assign epc         = reset   ? '0 :
                       irq     ? trap_vec :
                       is_mret ? mepc_q : '0;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed vector table with hand-derived expectations,
// then randomized cycles checked against a behavioural CSR model.
module tb_csr_file;
  import csr_file_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, csr_rd, csr_wr, is_mret, ext_intr, timer_intr;
  type_csr_op_e     csr_op;
  type_e2csr_data_s e2csr_data;
  logic [31:0] pc, csr_rdata, epc;
  logic csr_illegal, epc_taken;

  csr_file #(.BUS_WIDTH(32), .MTVEC_RST(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_op(csr_op),
    .e2csr_data(e2csr_data), .pc(pc), .is_mret(is_mret), .ext_intr(ext_intr),
    .timer_intr(timer_intr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .epc_taken(epc_taken), .epc(epc)
  );

  typedef struct {
    logic rd, wr; logic [1:0] op; logic [11:0] addr; logic [31:0] data, pc;
    logic mret, ext, tmr;
    logic [31:0] x_rdata; logic x_ill, x_taken; logic [31:0] x_epc;
    logic chk_rd, chk_ill;
  } vec_t;

  vec_t tbl[$];
  int n_total = 0, n_pass = 0;

  // Reference model state: architectural CSR contents.
  logic m_mie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] op, logic [11:0] a, logic [31:0] d,
                              logic [31:0] p, logic mr, logic e, logic t, logic [31:0] xr,
                              logic xi, logic xt, logic [31:0] xe, logic cr, logic ci);
    vec_t v;
    v.rd = rd; v.wr = wr; v.op = op; v.addr = a; v.data = d; v.pc = p;
    v.mret = mr; v.ext = e; v.tmr = t; v.x_rdata = xr; v.x_ill = xi;
    v.x_taken = xt; v.x_epc = xe; v.chk_rd = cr; v.chk_ill = ci;
    return v;
  endfunction

  function automatic vec_t rd_v(logic [11:0] a, logic [31:0] xr);
    return mk(1, 0, 2'b00, a, 0, 0, 0, 0, 0, xr, 0, 0, 0, 1, 1);
  endfunction

  function automatic vec_t wr_v(logic [1:0] op, logic [11:0] a, logic [31:0] d, logic [31:0] xr,
                                logic cr);
    return mk(1, 1, op, a, d, 0, 0, 0, 0, xr, 0, 0, 0, cr, 1);
  endfunction

  function automatic logic m_legal(logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80};
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a, logic e, logic t);
    case (a)
      12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(e) << 11) | (32'(t) << 7);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq(logic e, logic t);
    return m_mie && ((e && m_meie) || (t && m_mtie));
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0;
  endtask

  // Build expected outputs for a stimulus from the model.
  function automatic vec_t m_predict(vec_t v);
    logic [31:0] base, code;
    v.x_rdata = m_read(v.addr, v.ext, v.tmr);
    v.x_ill   = (v.rd || v.wr) && !m_legal(v.addr);
    v.chk_rd  = 1; v.chk_ill = 1;
    code = (v.ext && m_meie) ? 32'd11 : 32'd7;
    base = m_mtvec & ~32'h3;
    if (m_irq(v.ext, v.tmr)) begin
      v.x_taken = 1;
      v.x_epc   = (m_mtvec[1:0] == 2'b01) ? base + 4 * code : base;
    end else if (v.mret) begin
      v.x_taken = 1; v.x_epc = m_mepc;
    end else begin
      v.x_taken = 0; v.x_epc = 0;
    end
    return v;
  endfunction

  task automatic m_update(vec_t v);
    logic [31:0] old_v, nv;
    logic cyc_wr;
    old_v = m_read(v.addr, v.ext, v.tmr);
    cyc_wr = 0;
    if (m_irq(v.ext, v.tmr)) begin
      m_mcause = (v.ext && m_meie) ? 32'h8000_000B : 32'h8000_0007;
      m_mepc = v.pc & ~32'h3; m_mpie = m_mie; m_mie = 0;
    end else begin
      if (v.wr && v.op != 2'b00) begin
        nv = (v.op == 2'b01) ? v.data : (v.op == 2'b10) ? (old_v | v.data) : (old_v & ~v.data);
        case (v.addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: begin m_meie = nv[11]; m_mtie = nv[7]; end
          12'h305: m_mtvec = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: begin m_cyc[31:0] = nv; cyc_wr = 1; end
          12'hB80: begin m_cyc[63:32] = nv; cyc_wr = 1; end
          default: ;
        endcase
      end
      if (v.mret) begin m_mie = m_mpie; m_mpie = 1; end
    end
    if (!cyc_wr) m_cyc = m_cyc + 64'd1;
  endtask

  task automatic drive(vec_t v);
    csr_rd = v.rd; csr_wr = v.wr; csr_op = type_csr_op_e'(v.op);
    e2csr_data.data = v.data; e2csr_data.addr = {20'h0, v.addr};
    pc = v.pc; is_mret = v.mret; ext_intr = v.ext; timer_intr = v.tmr;
  endtask

  // Apply one cycle, compare at the falling edge, advance the model with the edge.
  task automatic run_vec(input string pfx, vec_t v);
    drive(v);
    @(negedge clk);
    if (v.chk_rd)  check({pfx, " rdata"}, csr_rdata, v.x_rdata);
    if (v.chk_ill) check({pfx, " illegal"}, 32'(csr_illegal), 32'(v.x_ill));
    check({pfx, " epc_taken"}, 32'(epc_taken), 32'(v.x_taken));
    check({pfx, " epc"}, epc, v.x_epc);
    m_update(v);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [11:0] a);
    reset = 1;
    drive(mk(1, 1, 2'b01, a, 32'hFFFF_FFFF, 32'h0000_0700, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("reset epc_taken", 32'(epc_taken), 32'h0);
      check("reset epc", epc, 32'h0);
      check("reset illegal", 32'(csr_illegal), 32'h0);
      @(posedge clk); #1;
    end
    reset = 0;
    m_reset();
    drive(rd_v(12'h000, 0));
  endtask

  initial begin
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'hFFF};
    vec_t v;

    // After reset
    tbl.push_back(rd_v(12'hB00, 0));
    tbl.push_back(rd_v(12'h300, 0));
    tbl.push_back(rd_v(12'h304, 0));
    tbl.push_back(rd_v(12'h342, 0));
    // mtvec read-modify-write
    tbl.push_back(wr_v(2'b01, 12'h305, 32'h100, 32'h0, 1));
    tbl.push_back(wr_v(2'b10, 12'h305, 32'h1, 32'h100, 1));
    tbl.push_back(wr_v(2'b11, 12'h305, 32'h1, 32'h101, 1));
    tbl.push_back(rd_v(12'h305, 32'h100));
    // External trap, direct mode
    tbl.push_back(wr_v(2'b01, 12'h304, 32'h800, 32'h0, 1));
    tbl.push_back(wr_v(2'b01, 12'h300, 32'h8, 32'h0, 1));
    tbl.push_back(mk(1, 0, 0, 12'h300, 0, 32'h40, 0, 1, 0, 32'h8, 0, 1, 32'h100, 1, 1));
    tbl.push_back(rd_v(12'h341, 32'h40));
    tbl.push_back(rd_v(12'h342, 32'h8000_000B));
    tbl.push_back(rd_v(12'h300, 32'h80));
    // mret from handler
    tbl.push_back(mk(1, 0, 0, 12'h300, 0, 32'h100, 1, 0, 0, 32'h80, 0, 1, 32'h40, 1, 1));
    tbl.push_back(rd_v(12'h300, 32'h88));
    // Vectored timer trap
    tbl.push_back(wr_v(2'b01, 12'h305, 32'h101, 32'h100, 1));
    tbl.push_back(wr_v(2'b01, 12'h304, 32'h880, 32'h800, 1));
    tbl.push_back(mk(1, 0, 0, 12'h305, 0, 32'h200, 0, 0, 1, 32'h101, 0, 1, 32'h11C, 1, 1));
    tbl.push_back(rd_v(12'h342, 32'h8000_0007));
    tbl.push_back(rd_v(12'h341, 32'h200));
    tbl.push_back(rd_v(12'h300, 32'h80));
    // Both pending: external wins
    tbl.push_back(wr_v(2'b01, 12'h300, 32'h8, 32'h80, 1));
    tbl.push_back(mk(1, 0, 0, 12'h344, 0, 32'h300, 0, 1, 1, 32'h880, 0, 1, 32'h12C, 1, 1));
    tbl.push_back(mk(1, 0, 0, 12'h342, 0, 0, 0, 1, 1, 32'h8000_000B, 0, 0, 0, 1, 1));
    // Trap beats mret and a concurrent CSR write
    tbl.push_back(wr_v(2'b01, 12'h300, 32'h88, 32'h80, 1));
    tbl.push_back(mk(1, 1, 2'b01, 12'h342, 32'h1234, 32'h500, 1, 1, 0,
                     32'h8000_000B, 0, 1, 32'h12C, 1, 1));
    tbl.push_back(rd_v(12'h341, 32'h500));
    tbl.push_back(rd_v(12'h342, 32'h8000_000B));
    tbl.push_back(rd_v(12'h300, 32'h80));
    // Unimplemented address and read-only mip
    tbl.push_back(mk(1, 1, 2'b01, 12'h7C0, 32'h5, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 2'b00, 12'h7C0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 2'b01, 12'h344, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0));
    tbl.push_back(rd_v(12'h344, 32'h0));
    tbl.push_back(rd_v(12'h305, 32'h101));
    // mcycle carry across halves
    tbl.push_back(wr_v(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(wr_v(2'b01, 12'hB80, 32'h0, 0, 0));
    tbl.push_back(rd_v(12'hB00, 32'hFFFF_FFFF));
    tbl.push_back(rd_v(12'hB80, 32'h1));
    tbl.push_back(rd_v(12'hB00, 32'h1));
    // Low-half write at all-ones: no carry into the high half
    tbl.push_back(wr_v(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(wr_v(2'b01, 12'hB00, 32'h5, 32'hFFFF_FFFF, 1));
    tbl.push_back(rd_v(12'hB80, 32'h1));
    tbl.push_back(rd_v(12'hB00, 32'h6));
    // 64-bit wrap
    tbl.push_back(wr_v(2'b01, 12'hB80, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(wr_v(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(rd_v(12'hB00, 32'hFFFF_FFFF));
    tbl.push_back(rd_v(12'hB80, 32'h0));
    tbl.push_back(rd_v(12'hB00, 32'h1));

    do_reset(12'h7C0);
    foreach (tbl[i]) run_vec($sformatf("row%0d", i), tbl[i]);

    // Reset in the middle of a handler, with a concurrent mtvec write
    run_vec("mid pre", wr_v(2'b01, 12'h300, 32'h8, 0, 0));
    run_vec("mid trap", mk(1, 0, 0, 12'h300, 0, 32'h600, 0, 1, 0, 32'h8, 0, 1, 32'h12C, 1, 1));
    do_reset(12'h305);
    run_vec("post mcycle", rd_v(12'hB00, 32'h0));
    run_vec("post mstatus", rd_v(12'h300, 32'h0));
    run_vec("post mie", rd_v(12'h304, 32'h0));
    run_vec("post mtvec", rd_v(12'h305, 32'h0));
    run_vec("post mepc", rd_v(12'h341, 32'h0));
    run_vec("post mcause", rd_v(12'h342, 32'h0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
             addrs[$urandom_range(0, 9)], $urandom, $urandom, 0,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 0, 0, 0, 0, 0, 0);
      if (v.addr == 12'h305) v.data[1] = 1'b0;
      if (!v.wr) v.mret = ($urandom_range(0, 7) == 0);
      run_vec($sformatf("rand%0d", i), m_predict(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
